// File: rtl/sipo_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : sipo_word_assembler
// Brief    : Framed serial-to-parallel word assembler with optional even parity.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_word_assembler #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sin,
    input  logic             en,
    input  logic             start,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             perr,
    output logic             busy
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sr;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   w_sr_next;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_sr_next = {r_sr[WIDTH-2:0], sin};
        end else begin : g_lsb_first
            assign w_sr_next = {sin, r_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            dout    <= '0;
            valid   <= 1'b0;
            perr    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            // start has priority in every state: it opens or restarts a frame
            if (start) begin
                r_state <= S_SHIFT;
                r_sr    <= '0;
                r_cnt   <= '0;
                busy    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_SHIFT: begin
                        if (en) begin
                            r_sr  <= w_sr_next;
                            r_cnt <= r_cnt + c_one;
                            if (r_cnt == c_last) begin
                                if (PARITY_EN != 0) begin
                                    r_state <= S_PARITY;
                                end else begin
                                    dout    <= w_sr_next;
                                    perr    <= 1'b0;
                                    valid   <= 1'b1;
                                    busy    <= 1'b0;
                                    r_state <= S_IDLE;
                                end
                            end
                        end
                    end
                    S_PARITY: begin
                        if (en) begin
                            dout    <= r_sr;
                            perr    <= (^r_sr) ^ sin;
                            valid   <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sipo_word_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sipo_word_assembler
// Brief    : Directed vector bench for sipo_word_assembler (WIDTH=4, MSB first, parity).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_word_assembler;

    logic       clk;
    logic       rstn;
    logic       sin;
    logic       en;
    logic       start;
    logic [3:0] dout;
    logic       valid;
    logic       perr;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    sipo_word_assembler #(
        .WIDTH    (4),
        .MSB_FIRST(1),
        .PARITY_EN(1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .sin  (sin),
        .en   (en),
        .start(start),
        .dout (dout),
        .valid(valid),
        .perr (perr),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       en;
        logic       sin;
        logic       exp_valid;
        logic       exp_busy;
        logic       exp_perr;
        logic [3:0] exp_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic e, input logic d,
                       input logic ev, input logic eb, input logic ep,
                       input logic [3:0] ed);
        vec_t v;
        v.start = s; v.en = e; v.sin = d;
        v.exp_valid = ev; v.exp_busy = eb; v.exp_perr = ep; v.exp_dout = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic ev, input logic eb, input logic ep,
                         input logic [3:0] ed);
        n_checks++;
        if (valid === ev && busy === eb && perr === ep && dout === ed) begin
            n_pass++;
        end else begin
            $display("FAIL %s[%0d]: got valid=%b busy=%b perr=%b dout=%b, expected valid=%b busy=%b perr=%b dout=%b",
                     name, idx, valid, busy, perr, dout, ev, eb, ep, ed);
        end
    endtask

    task automatic step(input logic s, input logic e, input logic d);
        start = s; en = e; sin = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; en = 1'b0; sin = 1'b0;

        // ---------------- vector table ----------------
        // good frame 1010, parity 0
        add(1,0,0, 0,1,0,4'b0000);
        add(0,1,1, 0,1,0,4'b0000);
        add(0,1,0, 0,1,0,4'b0000);
        add(0,1,1, 0,1,0,4'b0000);
        add(0,1,0, 0,1,0,4'b0000);
        add(0,1,0, 1,0,0,4'b1010);
        add(0,0,0, 0,0,0,4'b1010);
        // parity error: 1100 with parity 1; en/sin ignored while idle
        add(0,1,1, 0,0,0,4'b1010);
        add(1,1,1, 0,1,0,4'b1010);
        add(0,1,1, 0,1,0,4'b1010);
        add(0,1,1, 0,1,0,4'b1010);
        add(0,1,0, 0,1,0,4'b1010);
        add(0,1,0, 0,1,0,4'b1010);
        add(0,1,1, 1,0,1,4'b1100);
        for (int i = 0; i < 10; i++) add(0,0,0, 0,0,1,4'b1100);
        // gapped strobes: 0110, parity 0, two idle cycles between bits
        add(1,0,0, 0,1,1,4'b1100);
        begin
            logic [4:0] bits;
            bits = 5'b01100;
            for (int b = 4; b >= 1; b--) begin
                add(0,1,bits[b], 0,1,1,4'b1100);
                add(0,0,1,       0,1,1,4'b1100);
                add(0,0,1,       0,1,1,4'b1100);
            end
        end
        add(0,1,0, 1,0,0,4'b0110);
        add(0,0,0, 0,0,0,4'b0110);
        // abort: two bits, then restart with 0011 parity 0
        add(1,0,0, 0,1,0,4'b0110);
        add(0,1,1, 0,1,0,4'b0110);
        add(0,1,1, 0,1,0,4'b0110);
        add(1,1,1, 0,1,0,4'b0110);
        add(0,1,0, 0,1,0,4'b0110);
        add(0,1,0, 0,1,0,4'b0110);
        add(0,1,1, 0,1,0,4'b0110);
        add(0,1,1, 0,1,0,4'b0110);
        add(0,1,0, 1,0,0,4'b0011);
        // start in the valid cycle: frame 1001 parity 1 -> odd total -> perr
        add(1,0,0, 0,1,0,4'b0011);
        add(0,1,1, 0,1,0,4'b0011);
        add(0,1,0, 0,1,0,4'b0011);
        add(0,1,0, 0,1,0,4'b0011);
        add(0,1,1, 0,1,0,4'b0011);
        add(0,1,1, 1,0,1,4'b1001);
        add(0,0,0, 0,0,1,4'b1001);

        // ---------------- reset behaviour ----------------
        #2;
        check("reset_hold", 0, 0, 0, 0, 4'b0000);
        @(posedge clk); #1;
        check("reset_hold", 1, 0, 0, 0, 4'b0000);
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            check("post_reset_idle", i, 0, 0, 0, 4'b0000);
        end

        // ---------------- table replay ----------------
        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].en, vecs[i].sin);
            check("vec", i, vecs[i].exp_valid, vecs[i].exp_busy,
                  vecs[i].exp_perr, vecs[i].exp_dout);
        end

        // ---------------- reset mid-frame ----------------
        step(1, 0, 0);
        step(0, 1, 1); step(0, 1, 0); step(0, 1, 1); step(0, 1, 0);
        step(0, 1, 0);
        check("mid_pre_frame", 0, 1, 0, 0, 4'b1010);
        step(1, 0, 0);
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
        check("mid_busy", 0, 0, 1, 0, 4'b1010);
        start = 1'b0; en = 1'b0; sin = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("mid_async_reset", 0, 0, 0, 0, 4'b0000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b1;
        step(0, 1, 1);
        check("mid_after_release", 0, 0, 0, 0, 4'b0000);
        step(1, 0, 0);
        step(0, 1, 1); step(0, 1, 0); step(0, 1, 0); step(0, 1, 1);
        check("mid_fresh_busy", 0, 0, 1, 0, 4'b0000);
        step(0, 1, 0);
        check("mid_fresh_done", 0, 1, 0, 0, 4'b1001);
        step(0, 0, 0);
        check("mid_fresh_hold", 0, 0, 0, 0, 4'b1001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
